sine_rom_sequencer: RTL and testbench

- Phase-accumulator controller that sequences the sine-table ROM (WIDTH x DEPTH, 1-cycle registered read, read enable) to produce a sample stream.
- Generates the ROM enable and address on each sample strobe and realigns ROM output into a sample with a valid flag.
- Counts completed waveform periods and stops after a programmed number of periods, or runs until stopped.
- Sits between the control/config logic and the sine ROM; feeds the downstream DAC/sample path.

---
 rtl/sine_pkg.sv | 29 ++
 rtl/sine_rom_sequencer_phase_acc.sv | 51 +++++
 rtl/sine_rom_sequencer.sv | 159 +++++++++++++++
 tb/tb_sine_rom_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sine_pkg
//  Description : Shared state encoding and constants for the sine-table ROM
//                sequencer and its phase accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package sine_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Cycles spent in DRAIN so the last outstanding ROM read lands as a sample
    localparam int DRAIN_CYCLES = 2;
    // Registered-read latency of the sine ROM
    localparam int ROM_LATENCY  = 1;

    // Widths for the default 64-entry table with 8 fractional phase bits
    localparam int DEF_DEPTH = 64;
    localparam int DEF_FRAC  = 8;
    localparam int ADDR_W    = $clog2(DEF_DEPTH);
    localparam int ACC_W     = ADDR_W + DEF_FRAC;

endpackage : sine_pkg
`default_nettype wire

// File: rtl/sine_rom_sequencer_phase_acc.sv
`default_nettype none
// ============================================================================
//  Module      : phase_acc
//  Description : Phase accumulator with synchronous clear, add-step enable and
//                a carry-out wrap flag. Exposes only the integer (address) part.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_acc
    import sine_pkg::*;
#(
    parameter int ACC_BITS  = 14,
    parameter int FRAC_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          add_en,
    input  logic [ACC_BITS-1:0]           step,
    output logic [ACC_BITS-FRAC_BITS-1:0] addr,
    output logic                          wrap
);

    logic [ACC_BITS-1:0] acc_q;
    logic [ACC_BITS-1:0] acc_d;
    logic [ACC_BITS:0]   sum;

    // Next phase: clear wins over add; the extra sum bit is the period carry
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, step};
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = sum[ACC_BITS-1:0];
        end
    end

    // Phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign addr = acc_q[ACC_BITS-1:FRAC_BITS];
    assign wrap = add_en & sum[ACC_BITS];

endmodule : phase_acc
`default_nettype wire

// File: rtl/sine_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sine_rom_sequencer
//  Description : Drives a registered sine ROM from a phase accumulator on each
//                sample tick, realigns the ROM output into a sample stream and
//                stops after a programmed number of waveform periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_rom_sequencer
    import sine_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int FRAC  = 8,
    parameter int CNT_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               tick,
    input  logic [$clog2(DEPTH)+FRAC-1:0]      step,
    input  logic [CNT_W-1:0]                   num_periods,
    output logic                               rom_en,
    output logic [$clog2(DEPTH)-1:0]           rom_address,
    input  logic [WIDTH-1:0]                   rom_data,
    output logic [WIDTH-1:0]                   sample,
    output logic                               sample_valid,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_W-1:0]                   period_count
);

    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int ACC_BITS  = ADDR_BITS + FRAC;
    localparam int DRAIN_W   = $clog2(DRAIN_CYCLES + 1);

    state_t               state_q, state_d;
    logic [ACC_BITS-1:0]  step_q, step_d;
    logic [CNT_W-1:0]     nper_q, nper_d;
    logic [CNT_W-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]     pc_inc;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 done_q, done_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [WIDTH-1:0]     sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 acc_clear;
    logic                 acc_wrap;

    phase_acc #(
        .ACC_BITS  (ACC_BITS),
        .FRAC_BITS (FRAC)
    ) u_phase_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .add_en (rom_en),
        .step   (step_q),
        .addr   (rom_address),
        .wrap   (acc_wrap)
    );

    assign pc_inc = pc_q + 1'b1;

    // Sequencer FSM, period counting and ROM read request
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        nper_d      = nper_q;
        pc_d        = pc_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        acc_clear   = 1'b0;
        rom_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    step_d    = step;
                    nper_d    = num_periods;
                    pc_d      = '0;
                    acc_clear = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    // A tick coinciding with stop is dropped
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else if (tick) begin
                    rom_en = 1'b1;
                    if (acc_wrap) begin
                        if (pc_q != {CNT_W{1'b1}}) begin
                            pc_d = pc_inc;
                        end
                        // Finite run ends on the wrap that completes the last period
                        if ((nper_q != '0) && (pc_inc == nper_q)) begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                    done_d      = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ROM output realignment: data is valid the cycle after the read request
    always_comb begin
        rd_pend_d      = rom_en;
        sample_valid_d = rd_pend_q;
        sample_d       = rd_pend_q ? rom_data : sample_q;
    end

    // Control and sample registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            step_q         <= '0;
            nper_q         <= '0;
            pc_q           <= '0;
            drain_cnt_q    <= '0;
            done_q         <= 1'b0;
            rd_pend_q      <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            nper_q         <= nper_d;
            pc_q           <= pc_d;
            drain_cnt_q    <= drain_cnt_d;
            done_q         <= done_d;
            rd_pend_q      <= rd_pend_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign period_count = pc_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule : sine_rom_sequencer
`default_nettype wire

// File: tb/tb_sine_rom_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sine_rom_sequencer
//  Description : Self-checking bench for sine_rom_sequencer with a registered
//                ROM model, a behavioural sequencer model and a sample queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_rom_sequencer;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 64;
    localparam int FRAC   = 8;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 6;
    localparam int ACC_W  = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              tick = 1'b0;
    logic [ACC_W-1:0]  step = '0;
    logic [CNT_W-1:0]  num_periods = '0;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_address;
    logic [WIDTH-1:0]  rom_data;
    logic [WIDTH-1:0]  sample;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  period_count;

    sine_rom_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FRAC  (FRAC),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .tick         (tick),
        .step         (step),
        .num_periods  (num_periods),
        .rom_en       (rom_en),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
        .period_count (period_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] rom_word(input int i);
        return (32'(i) + 32'd1) * 32'h9E3779B1;
    endfunction

    // Registered-read sine ROM model
    always @(posedge clk) if (rom_en) rom_data <= rom_word(int'(rom_address));

    typedef struct {
        logic [WIDTH-1:0] data;
        int               at_cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;

    int checks = 0;
    int errors = 0;
    int n_samples = 0;
    logic [WIDTH-1:0] last_sample = '0;

    // Reference model of the sequencer
    int               m_state = 0;
    int               m_drain = 0;
    logic             m_done = 1'b0;
    logic [ACC_W-1:0] m_acc = '0;
    logic [ACC_W-1:0] m_step = '0;
    logic [CNT_W-1:0] m_nper = '0;
    logic [CNT_W-1:0] m_pc = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample monitor: every valid sample must match the oldest expected read
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            if (sb.size() == 0) begin
                chk("sample_unexpected", sample_valid, 1'b0);
            end else begin
                e_m = sb.pop_front();
                chk("sample_data", sample, e_m.data);
                chk("sample_latency", cyc, e_m.at_cyc);
                last_sample = e_m.data;
                n_samples++;
            end
        end
    end

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic cyc_step(input bit t, input bit s, input bit st);
        int nxt;
        int sum;
        logic done_nxt;
        @(posedge clk);
        #1;
        tick = t; stop = s; start = st;
        #1;
        chk("busy", busy, m_state != 0);
        chk("done", done, m_done);
        chk("rom_en", rom_en, (m_state == 1) && t && !s);
        chk("period_count", period_count, m_pc);
        nxt = m_state;
        done_nxt = 1'b0;
        case (m_state)
            0: if (st) begin
                m_step = step; m_nper = num_periods; m_acc = '0; m_pc = '0; nxt = 1;
            end
            1: if (s) begin
                nxt = 2; m_drain = 0;
            end else if (t) begin
                chk("rom_address", rom_address, m_acc[ACC_W-1:FRAC]);
                sb.push_back(exp_t'{data: rom_word(int'(m_acc[ACC_W-1:FRAC])), at_cyc: cyc + 2});
                sum = int'(m_acc) + int'(m_step);
                if (sum >= (1 << ACC_W)) begin
                    if ((int'(m_nper) != 0) && (int'(m_pc) + 1 == int'(m_nper))) nxt = 2;
                    m_drain = 0;
                    if (m_pc != 16'hFFFF) m_pc = m_pc + 1'b1;
                end
                m_acc = ACC_W'(sum);
            end
            default: begin
                m_drain++;
                if (m_drain == 2) begin nxt = 0; done_nxt = 1'b1; end
            end
        endcase
        m_state = nxt;
        m_done = done_nxt;
    endtask

    task automatic start_run(input logic [ACC_W-1:0] stp, input logic [CNT_W-1:0] np);
        step = stp;
        num_periods = np;
        cyc_step(0, 0, 1);
    endtask

    // Tick every 'every' cycles until the model returns to IDLE, within a cycle budget
    task automatic run_ticks(input int every, input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc_step((i % every) == 0, 0, 0);
            if (m_state == 0) break;
        end
        if (m_state != 0) chk("run_timeout", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    int n0;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_sample", sample, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_period_count", period_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // One period at one address per tick, tick every cycle
        n0 = n_samples;
        start_run(14'h100, 16'd1);
        run_ticks(1, 200);
        cyc_step(0, 0, 0);
        cyc_step(0, 0, 0);
        chk("t1_samples", n_samples - n0, 64);
        chk("t1_period_count", period_count, 1);
        chk("t1_sample_hold", sample, last_sample);

        // Half-address step, two periods, tick every 4th cycle
        n0 = n_samples;
        start_run(14'h080, 16'd2);
        run_ticks(4, 1200);
        cyc_step(0, 0, 0);
        cyc_step(0, 0, 0);
        chk("t2_samples", n_samples - n0, 256);
        chk("t2_period_count", period_count, 2);
        chk("t2_busy_after", busy, 0);

        // Continuous mode, stop together with the 10th tick, ticks during DRAIN
        n0 = n_samples;
        start_run(14'h100, 16'd0);
        repeat (9) cyc_step(1, 0, 0);
        cyc_step(1, 1, 0);
        cyc_step(1, 0, 0);
        cyc_step(1, 0, 0);
        cyc_step(0, 0, 0);
        cyc_step(0, 0, 0);
        chk("t3_samples", n_samples - n0, 9);
        chk("t3_sb_empty", sb.size(), 0);

        // start during RUN with a different step is ignored
        start_run(14'h100, 16'd0);
        repeat (5) cyc_step(1, 0, 0);
        step = 14'h200;
        cyc_step(1, 0, 1);
        repeat (5) cyc_step(1, 0, 0);
        cyc_step(0, 1, 0);
        repeat (4) cyc_step(0, 0, 0);

        // step = 0: address pinned at 0, no wraps
        start_run(14'h000, 16'd1);
        repeat (6) cyc_step(1, 0, 0);
        cyc_step(0, 1, 0);
        repeat (4) cyc_step(0, 0, 0);
        chk("t5_period_count", period_count, 0);

        // Asynchronous reset mid-run at address 20
        start_run(14'h100, 16'd0);
        repeat (20) cyc_step(1, 0, 0);
        @(posedge clk);
        #1 tick = 1'b1;
        #1 chk("t6_addr_before_rst", rom_address, 20);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_sample", sample, 0);
        chk("t6_rst_sample_valid", sample_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rom_en", rom_en, 0);
        chk("t6_rst_period_count", period_count, 0);
        sb.delete();
        m_state = 0; m_done = 1'b0; m_pc = '0; m_acc = '0;
        last_sample = '0;
        @(posedge clk);
        #1 rst = 1'b0; tick = 1'b0;
        cyc_step(0, 0, 0);
        cyc_step(0, 0, 0);
        n0 = n_samples;
        start_run(14'h100, 16'd1);
        run_ticks(1, 200);
        cyc_step(0, 0, 0);
        cyc_step(0, 0, 0);
        chk("t6_restart_samples", n_samples - n0, 64);

        // Large step: addresses 0,63,62,..., three periods
        n0 = n_samples;
        start_run(14'h3F00, 16'd3);
        run_ticks(1, 50);
        cyc_step(0, 0, 0);
        cyc_step(0, 0, 0);
        chk("t7_period_count", period_count, 3);
        chk("t7_samples", n_samples - n0, 4);
        chk("t7_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sine_rom_sequencer
`default_nettype wire
